evu_event_sampler: RTL and testbench

// - Downstream consumer of the EVU event output driven out of the ariane/cva6 top.
// - Counts per-event pulses over a programmable window of cycles.
// - At each window close, pushes one snapshot record into an internal FIFO.
// - The FIFO is drained by a valid/ready consumer (trace DMA or debug reader).

---
 rtl/evu_event_sampler.sv | 192 +++++++++++++++++++
 tb/tb_evu_event_sampler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/evu_event_sampler.sv
// Per-event pulse counter over programmable windows, with a show-ahead record FIFO drained by a valid/ready consumer.
// Optional: define EVU_SAMPLER_TIMESTAMP_EN to append a 32-bit cycle timestamp to each record.
module evu_event_sampler #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_W      = 16,
  parameter int WINDOW_W   = 16,
  parameter int FIFO_DEPTH = 8,
`ifdef EVU_SAMPLER_TIMESTAMP_EN
  localparam int REC_W     = NUM_EVENTS*CNT_W + 32,
`else
  localparam int REC_W     = NUM_EVENTS*CNT_W,
`endif
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [WINDOW_W-1:0]   window_len_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic                  rec_valid_o,
  input  logic                  rec_ready_i,
  output logic [REC_W-1:0]      rec_data_o,
  output logic                  rec_drop_o,
  output logic [CNT_W-1:0]      drop_cnt_o,
  output logic [LVL_W-1:0]      fifo_level_o,
  output logic                  busy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = NUM_EVENTS*CNT_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WINDOW_W-1:0] len_q;
  logic [WINDOW_W-1:0] timer_q;
  logic [WINDOW_W-1:0] len_sel;
  logic [CNT_W-1:0]    cnt_q   [NUM_EVENTS];
  logic [CNT_W-1:0]    cnt_inc [NUM_EVENTS];
  logic [CW-1:0]       rec_cnt;
  logic [REC_W-1:0]    rec_d;

  logic push;
  logic clear_win;
  logic latch_len;
  logic count_en;
  logic rec_incl;

  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign len_sel = (window_len_i == '0) ? WINDOW_W'(1) : window_len_i;

  always_comb begin
    for (int k = 0; k < NUM_EVENTS; k++) begin
      cnt_inc[k] = (event_i[k] && (cnt_q[k] != '1)) ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // A flush takes priority over a window close that would land on the same cycle;
  // that cycle's events are then excluded from the record.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    clear_win = 1'b0;
    latch_len = 1'b0;
    count_en  = 1'b0;
    rec_incl  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d   = S_RUN;
          clear_win = 1'b1;
          latch_len = 1'b1;
        end
      end
      S_RUN: begin
        if (!en_i) begin
          state_d   = S_FLUSH;
          push      = 1'b1;
          clear_win = 1'b1;
        end else if (timer_q == len_q - WINDOW_W'(1)) begin
          push      = 1'b1;
          rec_incl  = 1'b1;
          clear_win = 1'b1;
          latch_len = 1'b1;
        end else begin
          count_en  = 1'b1;
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_EVENTS; k++) cnt_q[k] <= '0;
      timer_q <= '0;
      len_q   <= '0;
    end else begin
      if (clear_win) begin
        for (int k = 0; k < NUM_EVENTS; k++) cnt_q[k] <= '0;
        timer_q <= '0;
      end else if (count_en) begin
        for (int k = 0; k < NUM_EVENTS; k++) cnt_q[k] <= cnt_inc[k];
        timer_q <= timer_q + WINDOW_W'(1);
      end
      if (latch_len) len_q <= len_sel;
    end
  end

  always_comb begin
    rec_cnt = '0;
    for (int k = 0; k < NUM_EVENTS; k++) begin
      rec_cnt[k*CNT_W +: CNT_W] = rec_incl ? cnt_inc[k] : cnt_q[k];
    end
  end

`ifdef EVU_SAMPLER_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_q + 32'd1;
  end

  assign rec_d = {ts_q, rec_cnt};
`else
  assign rec_d = rec_cnt;
`endif

  // Consumer handshake: rec_valid_o means the head entry is present in rec_data_o;
  // a record is transferred on any clock where rec_valid_o and rec_ready_i are both
  // high, and the head stays unchanged while valid is high and ready is low.
  assign full    = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop     = rec_valid_o && rec_ready_i;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= rec_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  // Storage is not reset, so the data output is masked whenever the FIFO is empty.
  assign rec_valid_o  = (level_q != '0);
  assign rec_data_o   = rec_valid_o ? mem_q[rd_ptr_q] : '0;
  assign rec_drop_o   = drop;
  assign drop_cnt_o   = drop_cnt_q;
  assign fifo_level_o = level_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_evu_event_sampler.sv
// Self-checking bench for evu_event_sampler: windows, flush, overflow, saturation and reset.
module tb_evu_event_sampler;

  localparam int NUM_EVENTS = 4;
  localparam int CNT_W      = 4;
  localparam int WINDOW_W   = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int CW         = NUM_EVENTS*CNT_W;
`ifdef EVU_SAMPLER_TIMESTAMP_EN
  localparam int REC_W      = CW + 32;
`else
  localparam int REC_W      = CW;
`endif
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic [WINDOW_W-1:0]   win_len;
  logic [NUM_EVENTS-1:0] ev;
  logic                  rec_valid;
  logic                  rec_ready;
  logic [REC_W-1:0]      rec_data;
  logic                  rec_drop;
  logic [CNT_W-1:0]      drop_cnt;
  logic [LVL_W-1:0]      fifo_level;
  logic                  busy;

  int checks   = 0;
  int failures = 0;
  int rec_seen = 0;
  logic [CW-1:0] exp_q[$];
  logic [31:0]   ts_seen[$];

  evu_event_sampler #(
    .NUM_EVENTS (NUM_EVENTS),
    .CNT_W      (CNT_W),
    .WINDOW_W   (WINDOW_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .window_len_i (win_len),
    .event_i      (ev),
    .rec_valid_o  (rec_valid),
    .rec_ready_i  (rec_ready),
    .rec_data_o   (rec_data),
    .rec_drop_o   (rec_drop),
    .drop_cnt_o   (drop_cnt),
    .fifo_level_o (fifo_level),
    .busy_o       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] rec4(input int c0, input int c1, input int c2, input int c3);
    logic [CW-1:0] r;
    r = '0;
    r[0*CNT_W +: CNT_W] = CNT_W'(c0);
    r[1*CNT_W +: CNT_W] = CNT_W'(c1);
    r[2*CNT_W +: CNT_W] = CNT_W'(c2);
    r[3*CNT_W +: CNT_W] = CNT_W'(c3);
    return r;
  endfunction

  function automatic logic [CW-1:0] rec_bits(input int v);
    logic [3:0] b;
    b = 4'(v);
    return rec4(int'(b[0]), int'(b[1]), int'(b[2]), int'(b[3]));
  endfunction

  // scoreboard: every accepted record is compared against the head of exp_q
  always @(negedge clk) begin
    if (!rst && rec_valid && rec_ready) begin
      rec_seen++;
`ifdef EVU_SAMPLER_TIMESTAMP_EN
      ts_seen.push_back(rec_data[REC_W-1 -: 32]);
`endif
      if (exp_q.size() == 0) check_val("rec_extra", 64'(rec_data[CW-1:0]), 64'hDEAD_0000_0000_0000);
      else                   check_val("rec_data", 64'(rec_data[CW-1:0]), 64'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check_val(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_valid"}, 64'(rec_valid), 64'd0);
    check_val({pfx, "_data"},  64'(rec_data),  64'd0);
    check_val({pfx, "_drop"},  64'(rec_drop),  64'd0);
    check_val({pfx, "_dcnt"},  64'(drop_cnt),  64'd0);
    check_val({pfx, "_level"}, 64'(fifo_level), 64'd0);
    check_val({pfx, "_busy"},  64'(busy),      64'd0);
  endtask

  initial begin
    int lat;
    int n;
    int drops;
    int base;

    rst = 1'b1; en = 1'b0; win_len = '0; ev = '0; rec_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // T1: len=4, event0 every cycle
    ts_seen.delete();
    win_len = 16'd4; ev = 4'b0001; rec_ready = 1'b1; en = 1'b1;
    repeat (3) exp_q.push_back(rec4(4, 0, 0, 0));
    exp_q.push_back(rec4(0, 0, 0, 0));
    lat = 0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n++;
      if (rec_valid) begin
        lat = i;
        break;
      end
    end
    check_val("t1_latency", 64'(lat), 64'd5);
    while (n < 13) begin
      tick();
      n++;
    end
    en = 1'b0; ev = '0;
    tick();
    tick();
    check_val("t1_busy", 64'(busy), 64'd0);
    wait_drain("t1_drain");
`ifdef EVU_SAMPLER_TIMESTAMP_EN
    if (ts_seen.size() >= 2) check_val("t1_ts_step", 64'(ts_seen[1] - ts_seen[0]), 64'd4);
    else                     check_val("t1_ts_count", 64'(ts_seen.size()), 64'd4);
`endif

    // T2: partial window flushed
    base = rec_seen;
    win_len = 16'd100; ev = '0; en = 1'b1;
    tick();
    ev = 4'b0010;
    repeat (10) tick();
    en = 1'b0;
    exp_q.push_back(rec4(0, 10, 0, 0));
    tick();
    check_val("t2_busy_flush", 64'(busy), 64'd1);
    tick();
    check_val("t2_busy_idle", 64'(busy), 64'd0);
    ev = '0;
    wait_drain("t2_drain");
    repeat (3) tick();
    check_val("t2_rec_count", 64'(rec_seen - base), 64'd1);

    // T3: overflow with consumer stalled, then T4: close on a full FIFO with a pop
    for (int i = 1; i <= 8; i++) exp_q.push_back(rec_bits(i));
    exp_q.push_back(rec_bits(13));
    exp_q.push_back(rec4(0, 0, 0, 0));
    rec_ready = 1'b0; win_len = 16'd1; ev = '0; en = 1'b1;
    tick();
    drops = 0;
    for (int i = 0; i < 12; i++) begin
      ev = 4'(i + 1);
      @(negedge clk);
      if (rec_drop) drops++;
      tick();
    end
    check_val("t3_level", 64'(fifo_level), 64'd8);
    check_val("t3_drops", 64'(drops), 64'd4);
    check_val("t3_drop_cnt", 64'(drop_cnt), 64'd4);
    check_val("t3_valid", 64'(rec_valid), 64'd1);
    ev = 4'd13; rec_ready = 1'b1;
    @(negedge clk);
    check_val("t4_no_drop", 64'(rec_drop), 64'd0);
    tick();
    check_val("t4_level", 64'(fifo_level), 64'd8);
    check_val("t4_drop_cnt", 64'(drop_cnt), 64'd4);
    en = 1'b0; ev = '0;
    tick();
    tick();
    wait_drain("t3_drain");

    // T5: saturation at 15
    win_len = 16'd40; ev = 4'b0100; rec_ready = 1'b1; en = 1'b1;
    exp_q.push_back(rec4(0, 0, 15, 0));
    exp_q.push_back(rec4(0, 0, 0, 0));
    tick();
    repeat (40) tick();
    en = 1'b0;
    tick();
    tick();
    ev = '0;
    wait_drain("t5_drain");

    // window length 0 behaves as 1
    win_len = 16'd0; ev = 4'b1000; en = 1'b1;
    repeat (3) exp_q.push_back(rec4(0, 0, 0, 1));
    exp_q.push_back(rec4(0, 0, 0, 0));
    tick();
    repeat (3) tick();
    en = 1'b0;
    tick();
    tick();
    ev = '0;
    wait_drain("len0_drain");

    // T6: asynchronous reset with records buffered
    rec_ready = 1'b0; win_len = 16'd1; ev = 4'b0001; en = 1'b1;
    tick();
    repeat (3) tick();
    check_val("t6_level_pre", 64'(fifo_level), 64'd3);
    #2;
    rst = 1'b1; en = 1'b0; ev = '0;
    #1;
    check_all_zero("t6_rst");
    tick();
    rst = 1'b0;
    ts_seen.delete();
    en = 1'b1; win_len = 16'd1; rec_ready = 1'b1;
    exp_q.push_back(rec4(0, 0, 0, 0));
    exp_q.push_back(rec4(0, 0, 0, 0));
    tick();
    check_val("t6_level_post", 64'(fifo_level), 64'd0);
    tick();
    en = 1'b0;
    tick();
    tick();
    wait_drain("t6_drain");
`ifdef EVU_SAMPLER_TIMESTAMP_EN
    if (ts_seen.size() >= 1) check_val("t6_ts_restart", 64'(ts_seen[0]), 64'd1);
    else                     check_val("t6_ts_count", 64'(ts_seen.size()), 64'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
